// File: rtl/mppt_po_sequencer.sv
// ---------------------------------------------------------------------------
// mppt_po_sequencer
//
// Perturb-and-observe maximum-power-point tracker. Shares one 8-bit ADC
// between panel voltage and current, forms a 16-bit power estimate and steps
// the PWM duty toward maximum power once per settle period.
//
// Optional feature macro: MPPT_SOFTSTART_EN
//   When defined, leaving reset or IDLE first ramps duty from DUTY_MIN up to
//   DUTY_INIT in STEP increments, one step per settle period, with no ADC
//   traffic, before normal tracking starts.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous active-high reset
//   enable    in   tracking enable (level); low returns to IDLE
//   adc_req   out  conversion request, held until acknowledged
//   adc_sel   out  channel select, 0 = voltage, 1 = current
//   adc_ack   in   one-cycle acknowledge, adc_data valid in same cycle
//   adc_data  in   8-bit unsigned sample
//   duty      out  8-bit PWM duty command
//   duty_upd  out  one-cycle strobe whenever duty is written
//   power     out  last computed V x I (16-bit)
//   dir       out  perturbation direction, 1 = increase
//   busy      out  high in every state except IDLE
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mppt_po_sequencer #(
  parameter int unsigned DUTY_INIT  = 128,
  parameter int unsigned DUTY_MIN   = 16,
  parameter int unsigned DUTY_MAX   = 240,
  parameter int unsigned STEP       = 4,
  parameter int unsigned SETTLE_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_req,
  output logic        adc_sel,
  input  logic        adc_ack,
  input  logic [7:0]  adc_data,
  output logic [7:0]  duty,
  output logic        duty_upd,
  output logic [15:0] power,
  output logic        dir,
  output logic        busy
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  localparam logic [8:0] MIN9  = 9'(DUTY_MIN);
  localparam logic [8:0] MAX9  = 9'(DUTY_MAX);
  localparam logic [7:0] INIT8 = 8'(DUTY_INIT);
  localparam logic [7:0] MIN8  = 8'(DUTY_MIN);
  localparam logic [7:0] MAX8  = 8'(DUTY_MAX);

  typedef enum logic [2:0] {
    IDLE, RAMP, SETTLE, REQ_V, REQ_I, CALC, DECIDE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      v_q, i_q;
  logic [7:0]      duty_q;
  logic            dir_q;
  logic [15:0]     power_q, pPrev_q;
  logic            adcReq_q, adcSel_q, dutyUpd_q, busy_q;

  logic            decDir_d;
  logic [7:0]      decDuty_d;
  logic            turnDir;
  logic [8:0]      cand;

  // Decision math for DECIDE. The 9-bit candidate never wraps: a decrement
  // below zero saturates at 0 so it always lands in the lower clamp.
  always_comb begin
    turnDir = (power_q < pPrev_q) ? ~dir_q : dir_q;
    if (turnDir)
      cand = {1'b0, duty_q} + STEP9;
    else if ({1'b0, duty_q} > STEP9)
      cand = {1'b0, duty_q} - STEP9;
    else
      cand = 9'd0;
    decDuty_d = cand[7:0];
    decDir_d  = turnDir;
    if (cand >= MAX9) begin
      decDuty_d = MAX8;
      decDir_d  = 1'b0;
    end else if (cand <= MIN9) begin
      decDuty_d = MIN8;
      decDir_d  = 1'b1;
    end
  end

`ifdef MPPT_SOFTSTART_EN
  logic [8:0] rampCand;
  always_comb rampCand = {1'b0, duty_q} + STEP9;
`endif

  // Main sequencer. Disable has priority over everything, including an ack
  // arriving in the same cycle, so a half-finished measurement is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      v_q       <= '0;
      i_q       <= '0;
      duty_q    <= INIT8;
      dir_q     <= 1'b1;
      power_q   <= '0;
      pPrev_q   <= '0;
      adcReq_q  <= 1'b0;
      adcSel_q  <= 1'b0;
      dutyUpd_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dutyUpd_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        adcReq_q <= 1'b0;
        adcSel_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
`ifdef MPPT_SOFTSTART_EN
            state_q   <= RAMP;
            duty_q    <= MIN8;
            dutyUpd_q <= 1'b1;
`else
            state_q <= SETTLE;
`endif
          end
`ifdef MPPT_SOFTSTART_EN
          RAMP: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q     <= '0;
              dutyUpd_q <= 1'b1;
              if (rampCand >= {1'b0, INIT8}) begin
                duty_q  <= INIT8;
                state_q <= SETTLE;
              end else begin
                duty_q <= rampCand[7:0];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`endif
          SETTLE: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q    <= '0;
              state_q  <= REQ_V;
              adcReq_q <= 1'b1;
              adcSel_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          REQ_V: begin
            if (adc_ack) begin
              v_q      <= adc_data;
              adcSel_q <= 1'b1;
              state_q  <= REQ_I;
            end
          end
          REQ_I: begin
            if (adc_ack) begin
              i_q      <= adc_data;
              adcReq_q <= 1'b0;
              adcSel_q <= 1'b0;
              state_q  <= CALC;
            end
          end
          CALC: begin
            power_q <= {8'd0, v_q} * {8'd0, i_q};
            state_q <= DECIDE;
          end
          DECIDE: begin
            duty_q    <= decDuty_d;
            dir_q     <= decDir_d;
            dutyUpd_q <= 1'b1;
            pPrev_q   <= power_q;
            cnt_q     <= '0;
            state_q   <= SETTLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign adc_req  = adcReq_q;
  assign adc_sel  = adcSel_q;
  assign duty     = duty_q;
  assign duty_upd = dutyUpd_q;
  assign power    = power_q;
  assign dir      = dir_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mppt_po_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mppt_po_sequencer
//
// Self-checking bench for mppt_po_sequencer with SETTLE_CYC=4, STEP=4,
// DUTY_INIT=128, DUTY_MIN=16, DUTY_MAX=240. Expected decisions are pushed to
// a scoreboard queue when the current sample is acknowledged and popped on
// each duty_upd strobe. With MPPT_SOFTSTART_EN defined the duty ramp is
// checked first.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mppt_po_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        adcAck;
  logic [7:0]  adcData;
  logic        adc_req, adc_sel, duty_upd, dir, busy;
  logic [7:0]  duty;
  logic [15:0] power;

  mppt_po_sequencer #(
    .DUTY_INIT(128), .DUTY_MIN(16), .DUTY_MAX(240), .STEP(4), .SETTLE_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .adc_req(adc_req), .adc_sel(adc_sel),
    .adc_ack(adcAck), .adc_data(adcData),
    .duty(duty), .duty_upd(duty_upd), .power(power),
    .dir(dir), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [15:0] power;
    logic [7:0]  duty;
    logic        dir;
    int          ackCycle;
  } expRec_t;

  typedef struct {
    logic [7:0]  v;
    logic [7:0]  i;
    logic [15:0] expPower;
    logic [7:0]  expDuty;
    logic        expDir;
  } vec_t;

  expRec_t sbQ[$];
  vec_t    vecs[8];

  logic [7:0]  mDuty = 8'd128;
  logic        mDir  = 1'b1;
  logic [15:0] mPrev = 16'd0;

  bit rampMode = 1'b0;
  int rampExp  = 16;
  int rampLast = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Independent duty/dir model in plain integer arithmetic.
  function automatic logic [8:0] modelNext(input logic [7:0] d, input logic dr,
                                           input logic [15:0] p,
                                           input logic [15:0] prev);
    logic nd;
    int   c;
    nd = (p < prev) ? ~dr : dr;
    c  = nd ? int'(d) + 4 : int'(d) - 4;
    if (c >= 240) return {1'b0, 8'd240};
    if (c <= 16)  return {1'b1, 8'd16};
    return {nd, 8'(c)};
  endfunction

  // Scoreboard / ramp monitor, sampled away from the active edge.
  always @(negedge clk) begin
    expRec_t rec;
    if (rampMode) checkOutput("rampNoReq", {31'd0, adc_req}, 32'd0);
    if (!rst && duty_upd) begin
      if (rampMode) begin
        checkOutput("rampDuty", {24'd0, duty}, rampExp);
        if (rampExp != 16) checkOutput("rampSpacing", cycle - rampLast, 4);
        rampLast = cycle;
        rampExp += 4;
      end else if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedUpd actual=%0d expected=none", duty);
      end else begin
        rec = sbQ.pop_front();
        checkOutput("updPower", {16'd0, power}, {16'd0, rec.power});
        checkOutput("updDuty", {24'd0, duty}, {24'd0, rec.duty});
        checkOutput("updDir", {31'd0, dir}, {31'd0, rec.dir});
        checkOutput("updLatency", cycle - rec.ackCycle, 2);
      end
    end
  end

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (adc_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL reqTimeout actual=0 expected=1");
    end else begin
      checkOutput("reqSelV", {31'd0, adc_sel}, 32'd0);
    end
  endtask

  // One full measurement: voltage then current handshake, then wait for the
  // matching duty_upd to drain the scoreboard.
  task automatic applyStimulus(input logic [7:0] v, input logic [7:0] i,
                               input logic [15:0] ePow, input logic [7:0] eDuty,
                               input logic eDir);
    bit      ok;
    expRec_t rec;
    waitReq(ok);
    if (!ok) return;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    checkOutput("reqHeldV", {30'd0, adc_req, adc_sel}, 32'd2);
    adcData = v;
    adcAck  = 1'b1;
    @(posedge clk);
    #1 adcAck = 1'b0;
    @(negedge clk);
    checkOutput("reqSwitchI", {30'd0, adc_req, adc_sel}, 32'd3);
    adcData      = i;
    adcAck       = 1'b1;
    rec.power    = ePow;
    rec.duty     = eDuty;
    rec.dir      = eDir;
    rec.ackCycle = cycle + 1;
    sbQ.push_back(rec);
    @(posedge clk);
    #1 adcAck = 1'b0;
    @(negedge clk);
    checkOutput("reqDrop", {31'd0, adc_req}, 32'd0);
    @(negedge clk);
    checkOutput("powerEarly", {16'd0, power}, {16'd0, ePow});
    for (int k = 0; k < 10 && sbQ.size() != 0; k++) @(negedge clk);
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL updTimeout actual=missing expected=duty %0d", eDuty);
      sbQ.delete();
    end
    mDuty = eDuty;
    mDir  = eDir;
    mPrev = ePow;
  endtask

  initial begin
    logic [8:0] nx;
    bit         ok;

    vecs[0] = '{8'd100, 8'd50, 16'd5000,  8'd132, 1'b1};
    vecs[1] = '{8'd100, 8'd60, 16'd6000,  8'd136, 1'b1};
    vecs[2] = '{8'd100, 8'd40, 16'd4000,  8'd132, 1'b0};
    vecs[3] = '{8'd100, 8'd40, 16'd4000,  8'd128, 1'b0};
    vecs[4] = '{8'd200, 8'd200, 16'd40000, 8'd124, 1'b0};
    vecs[5] = '{8'd255, 8'd255, 16'd65025, 8'd120, 1'b0};
    vecs[6] = '{8'd10,  8'd10, 16'd100,   8'd124, 1'b1};
    vecs[7] = '{8'd20,  8'd20, 16'd400,   8'd128, 1'b1};

    rst     = 1'b1;
    enable  = 1'b0;
    adcAck  = 1'b0;
    adcData = 8'd0;
    #1;
    checkOutput("rstDuty", {24'd0, duty}, 128);
    checkOutput("rstDir", {31'd0, dir}, 1);
    checkOutput("rstPower", {16'd0, power}, 0);
    checkOutput("rstReq", {31'd0, adc_req}, 0);
    checkOutput("rstSel", {31'd0, adc_sel}, 0);
    checkOutput("rstBusy", {31'd0, busy}, 0);
    checkOutput("rstUpd", {31'd0, duty_upd}, 0);
    #20;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checkOutput("idleBusy", {31'd0, busy}, 0);

`ifdef MPPT_SOFTSTART_EN
    rampMode = 1'b1;
    rampExp  = 16;
    enable   = 1'b1;
    for (int k = 0; k < 200 && rampExp <= 128; k++) @(negedge clk);
    checkOutput("rampDone", rampExp, 132);
    repeat (2) @(negedge clk);
    rampMode = 1'b0;
`else
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("enBusy", {31'd0, busy}, 1);
    checkOutput("enNoReq", {31'd0, adc_req}, 0);
    repeat (3) @(negedge clk);
    checkOutput("settleNoReq", {31'd0, adc_req}, 0);
    @(negedge clk);
    checkOutput("settleReq", {31'd0, adc_req}, 1);
`endif

    for (int n = 0; n < 8; n++)
      applyStimulus(vecs[n].v, vecs[n].i, vecs[n].expPower,
                    vecs[n].expDuty, vecs[n].expDir);

    // Constant power climbs to the upper clamp, turns, descends to the lower
    // clamp, turns again and takes one more step up.
    begin
      bit reachedMin = 1'b0;
      bit done       = 1'b0;
      for (int k = 0; k < 120 && !done; k++) begin
        if (reachedMin) done = 1'b1;
        nx = modelNext(mDuty, mDir, 16'd2500, mPrev);
        if (nx[7:0] == 8'd16) reachedMin = 1'b1;
        applyStimulus(8'd50, 8'd50, 16'd2500, nx[7:0], nx[8]);
      end
    end
    checkOutput("climbDuty", {24'd0, duty}, 20);
    checkOutput("climbDir", {31'd0, dir}, 1);

`ifndef MPPT_SOFTSTART_EN
    // Abort during REQ_V; a later ack must be ignored.
    waitReq(ok);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("abortReq", {31'd0, adc_req}, 0);
    checkOutput("abortBusy", {31'd0, busy}, 0);
    checkOutput("abortDuty", {24'd0, duty}, {24'd0, mDuty});
    adcData = 8'd77;
    adcAck  = 1'b1;
    @(negedge clk);
    adcAck  = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("ignAckReq", {31'd0, adc_req}, 0);
    checkOutput("ignAckDuty", {24'd0, duty}, {24'd0, mDuty});
    checkOutput("ignAckPower", {16'd0, power}, {16'd0, mPrev});

    // Disable in the same cycle as the current ack: sample discarded, the
    // next run starts again with a voltage request.
    enable = 1'b1;
    waitReq(ok);
    adcData = 8'd90;
    adcAck  = 1'b1;
    @(posedge clk);
    #1 adcAck = 1'b0;
    @(negedge clk);
    checkOutput("preAbortSel", {31'd0, adc_sel}, 1);
    adcData = 8'd90;
    adcAck  = 1'b1;
    enable  = 1'b0;
    @(posedge clk);
    #1 adcAck = 1'b0;
    @(negedge clk);
    checkOutput("raceReq", {31'd0, adc_req}, 0);
    checkOutput("raceBusy", {31'd0, busy}, 0);
    repeat (4) @(negedge clk);
    checkOutput("racePower", {16'd0, power}, {16'd0, mPrev});
    enable = 1'b1;
    nx = modelNext(mDuty, mDir, 16'd3000, mPrev);
    applyStimulus(8'd100, 8'd30, 16'd3000, nx[7:0], nx[8]);
    checkOutput("resumeDuty", {24'd0, duty}, 24);
`endif

    // Reset asserted between edges takes effect without a clock.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncDuty", {24'd0, duty}, 128);
    checkOutput("asyncPower", {16'd0, power}, 0);
    checkOutput("asyncBusy", {31'd0, busy}, 0);
    checkOutput("asyncDir", {31'd0, dir}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
